// File: rtl/gray_step_sequencer_if.sv
// ----------------------------------------------------------------------------
// gray_step_sequencer_if
// Control and status bundle for gray_step_sequencer.
//   master: requester side (drives start/dir/num_steps/dwell/abort,
//           observes code/step_pulse/busy/done/aborted/steps_left)
//   slave : sequencer side (the reverse directions)
// ----------------------------------------------------------------------------
interface gray_step_sequencer_if #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               dir;
    logic [CNT_W-1:0]   num_steps;
    logic [DWELL_W-1:0] dwell;
    logic               abort;
    logic [1:0]         code;
    logic               step_pulse;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [CNT_W-1:0]   steps_left;

    modport master (
        output start, dir, num_steps, dwell, abort,
        input  code, step_pulse, busy, done, aborted, steps_left
    );

    modport slave (
        input  start, dir, num_steps, dwell, abort,
        output code, step_pulse, busy, done, aborted, steps_left
    );
endinterface

// File: rtl/gray_step_sequencer.sv
// ----------------------------------------------------------------------------
// gray_step_sequencer
// Emits a programmed number of 2-bit Gray-code steps, forward or reverse, with
// a programmable dwell between steps. The code position persists across runs.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : gray_step_sequencer_if.slave
//         in : start, dir, num_steps, dwell, abort
//         out: code, step_pulse, busy, done, aborted, steps_left
// ----------------------------------------------------------------------------
module gray_step_sequencer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DWELL_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    gray_step_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_code;
    logic               r_step_pulse;
    logic               r_aborted;
    logic               r_dir;
    logic [CNT_W-1:0]   r_steps_left;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;

    logic [1:0]         w_code_next;

    // Forward order 00->01->11->10->00; reverse walks the same ring backwards.
    always_comb begin
        w_code_next = r_code;
        if (!r_dir) begin
            case (r_code)
                2'b00:   w_code_next = 2'b01;
                2'b01:   w_code_next = 2'b11;
                2'b11:   w_code_next = 2'b10;
                default: w_code_next = 2'b00;
            endcase
        end else begin
            case (r_code)
                2'b00:   w_code_next = 2'b10;
                2'b10:   w_code_next = 2'b11;
                2'b11:   w_code_next = 2'b01;
                default: w_code_next = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_code       <= 2'b00;
            r_step_pulse <= 1'b0;
            r_aborted    <= 1'b0;
            r_dir        <= 1'b0;
            r_steps_left <= '0;
            r_dwell      <= '0;
            r_dwell_cnt  <= '0;
        end else begin
            r_step_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dir        <= bus.dir;
                        r_dwell      <= bus.dwell;
                        r_steps_left <= bus.num_steps;
                        r_aborted    <= 1'b0;
                        if (bus.num_steps == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state     <= S_RUN;
                            r_dwell_cnt <= bus.dwell;
                        end
                    end
                end
                S_RUN: begin
                    // Abort outranks a step that falls due on the same edge.
                    if (bus.abort) begin
                        r_state   <= S_DONE;
                        r_aborted <= 1'b1;
                    end else if (r_dwell_cnt != '0) begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                    end else begin
                        r_code       <= w_code_next;
                        r_step_pulse <= 1'b1;
                        r_steps_left <= r_steps_left - CNT_W'(1);
                        r_dwell_cnt  <= r_dwell;
                        if (r_steps_left == CNT_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.code       = r_code;
    assign bus.step_pulse = r_step_pulse;
    assign bus.busy       = (r_state == S_RUN);
    assign bus.done       = (r_state == S_DONE);
    assign bus.aborted    = r_aborted;
    assign bus.steps_left = r_steps_left;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gray_step_sequencer
// Directed bench for gray_step_sequencer. Each scenario task drives stimulus
// and compares {code, step_pulse, busy, done} plus status against
// hand-computed values, sampling 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_gray_step_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [1:0] fwd_seq [4];
    logic [1:0] rev_seq [4];

    gray_step_sequencer_if #(.CNT_W(8), .DWELL_W(8)) bus ();

    gray_step_sequencer #(.CNT_W(8), .DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst = 1'b0;
        bus.start = 1'b0; bus.dir = 1'b0; bus.num_steps = '0;
        bus.dwell = '0;   bus.abort = 1'b0;
        tick(); tick();
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b00_0_0_0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, 5'b00_0_0_0);
        end
        checks++;
        if ({bus.aborted, bus.steps_left} !== 9'd0) begin
            failures++;
            $display("FAIL reset_status got=%b/%0d exp=0/0", bus.aborted, bus.steps_left);
        end
        rst = 1'b1;
        tick();
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b00_0_0_0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", obs, 5'b00_0_0_0);
        end
    endtask

    // dir=0, 5 steps, dwell 0 from 00: 01,11,10,00,01 on consecutive edges.
    task automatic test_forward();
        logic [1:0] exp_code [5];
        logic [4:0] obs, exp;
        exp_code = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        bus.start = 1'b1; bus.dir = 1'b0; bus.num_steps = 8'd5; bus.dwell = 8'd0;
        tick();
        bus.start = 1'b0; bus.num_steps = 8'd77; bus.dir = 1'b1;
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b00_0_1_0) begin
            failures++;
            $display("FAIL fwd_start got=%b exp=%b", obs, 5'b00_0_1_0);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp = {exp_code[k-1], 1'b1, (k < 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0};
            obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL fwd_step k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        checks++;
        if (bus.steps_left !== 8'd0) begin
            failures++;
            $display("FAIL fwd_steps_left got=%0d exp=0", bus.steps_left);
        end
        tick();
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b01_0_0_0) begin
            failures++;
            $display("FAIL fwd_end got=%b exp=%b", obs, 5'b01_0_0_0);
        end
    endtask

    // dir=1, 3 steps, dwell 2 from 01: 00,10,11 at edges 3,6,9.
    task automatic test_reverse();
        logic [4:0] obs, exp;
        int n;
        int done_cnt;
        done_cnt = 0;
        bus.start = 1'b1; bus.dir = 1'b1; bus.num_steps = 8'd3; bus.dwell = 8'd2;
        tick();
        bus.start = 1'b0; bus.dir = 1'b0; bus.dwell = 8'd0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n = (c / 3 > 3) ? 3 : c / 3;
            exp = {rev_seq[n],
                   ((c % 3 == 0) && (c <= 9)) ? 1'b1 : 1'b0,
                   (c < 9) ? 1'b1 : 1'b0,
                   (c == 9) ? 1'b1 : 1'b0};
            obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
            if (bus.done === 1'b1) done_cnt++;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rev_cycle c=%0d got=%b exp=%b", c, obs, exp);
            end
        end
        checks++;
        if (done_cnt != 1 || bus.aborted !== 1'b0) begin
            failures++;
            $display("FAIL rev_done_once got=%0d/%b exp=1/0", done_cnt, bus.aborted);
        end
    endtask

    // num_steps=0 from 11: done next cycle, never busy, no step.
    task automatic test_zero_steps();
        logic [4:0] obs;
        bus.start = 1'b1; bus.dir = 1'b1; bus.num_steps = 8'd0; bus.dwell = 8'd5;
        tick();
        bus.start = 1'b0;
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b11_0_0_1) begin
            failures++;
            $display("FAIL zero_done got=%b exp=%b", obs, 5'b11_0_0_1);
        end
        tick();
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b11_0_0_0) begin
            failures++;
            $display("FAIL zero_idle got=%b exp=%b", obs, 5'b11_0_0_0);
        end
    endtask

    // dir=0, 10 steps, dwell 1 from 11; abort on edge 6 where step 3 is due.
    task automatic test_abort();
        logic [4:0] obs, exp;
        bus.start = 1'b1; bus.dir = 1'b0; bus.num_steps = 8'd10; bus.dwell = 8'd1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp = {fwd_seq[(2 + c / 2) % 4], (c % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0};
            obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL abort_run c=%0d got=%b exp=%b", c, obs, exp);
            end
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b00_0_0_1) begin
            failures++;
            $display("FAIL abort_edge got=%b exp=%b", obs, 5'b00_0_0_1);
        end
        checks++;
        if ({bus.aborted, bus.steps_left} !== {1'b1, 8'd8}) begin
            failures++;
            $display("FAIL abort_status got=%b/%0d exp=1/8", bus.aborted, bus.steps_left);
        end
        tick();
        // abort while idle must do nothing
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b00_0_0_0 || bus.aborted !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle got=%b/%b exp=%b/1", obs, bus.aborted, 5'b00_0_0_0);
        end
        bus.start = 1'b1; bus.dir = 1'b0; bus.num_steps = 8'd1; bus.dwell = 8'd0;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.aborted !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_clear got=%b/%b exp=0/1", bus.aborted, bus.busy);
        end
        tick();
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b01_1_0_1) begin
            failures++;
            $display("FAIL abort_rerun got=%b exp=%b", obs, 5'b01_1_0_1);
        end
        tick();
    endtask

    // Reset mid-run after 2 steps from 01: immediate return to reset values.
    task automatic test_reset_midrun();
        logic [4:0] obs;
        bus.start = 1'b1; bus.dir = 1'b0; bus.num_steps = 8'd10; bus.dwell = 8'd0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b10_1_1_0) begin
            failures++;
            $display("FAIL rst_pre got=%b exp=%b", obs, 5'b10_1_1_0);
        end
        #2 rst = 1'b0;
        #1;
        obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
        checks++;
        if (obs !== 5'b00_0_0_0 || bus.steps_left !== 8'd0) begin
            failures++;
            $display("FAIL rst_async got=%b/%0d exp=%b/0", obs, bus.steps_left, 5'b00_0_0_0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
            checks++;
            if (obs !== 5'b00_0_0_0) begin
                failures++;
                $display("FAIL rst_after c=%0d got=%b exp=%b", c, obs, 5'b00_0_0_0);
            end
        end
    endtask

    // 255 forward steps from 00 ending at 10; start pulses in RUN/DONE ignored.
    task automatic test_back_to_back();
        logic [4:0] obs, exp;
        bus.start = 1'b1; bus.dir = 1'b0; bus.num_steps = 8'd255; bus.dwell = 8'd0;
        tick();
        for (int c = 1; c <= 255; c++) begin
            if (c == 10 || c == 100) begin
                bus.start = 1'b1; bus.dir = 1'b1; bus.num_steps = 8'd3; bus.dwell = 8'd4;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            exp = {fwd_seq[c % 4], 1'b1, (c < 255) ? 1'b1 : 1'b0, (c == 255) ? 1'b1 : 1'b0};
            obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL long_run c=%0d got=%b exp=%b", c, obs, exp);
            end
        end
        // start while in DONE must not launch another run
        bus.start = 1'b1; bus.num_steps = 8'd4;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            obs = {bus.code, bus.step_pulse, bus.busy, bus.done};
            checks++;
            if (obs !== 5'b10_0_0_0 || bus.steps_left !== 8'd0) begin
                failures++;
                $display("FAIL done_start c=%0d got=%b/%0d exp=%b/0",
                         c, obs, bus.steps_left, 5'b10_0_0_0);
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fwd_seq  = '{2'b00, 2'b01, 2'b11, 2'b10};
        rev_seq  = '{2'b01, 2'b00, 2'b10, 2'b11};
        test_reset();
        test_forward();
        test_reverse();
        test_zero_steps();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
